// File: rtl/move_eval_pkg.sv
// Shared types, edge tables and move helpers for the TSP move evaluator.
package move_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    CMP   = 2'd3
  } state_t;

  typedef enum logic {
    MV_SWAP = 1'b0,
    MV_2OPT = 1'b1
  } mode_t;

  localparam int N_EDGES_SWAP = 4;
  localparam int N_EDGES_2OPT = 2;

  // Endpoint pair {a,b} (0-based point indices) for issue slot idx; old edges come first.
  function automatic logic [5:0] edge_pair(input mode_t mode, input logic [2:0] idx);
    logic [5:0] pair;
    pair = 6'd0;
    if (mode == MV_SWAP) begin
      case (idx)
        3'd0:    pair = {3'd0, 3'd1};
        3'd1:    pair = {3'd1, 3'd2};
        3'd2:    pair = {3'd3, 3'd4};
        3'd3:    pair = {3'd4, 3'd5};
        3'd4:    pair = {3'd0, 3'd4};
        3'd5:    pair = {3'd4, 3'd2};
        3'd6:    pair = {3'd3, 3'd1};
        3'd7:    pair = {3'd1, 3'd5};
        default: pair = {3'd0, 3'd0};
      endcase
    end else begin
      case (idx)
        3'd0:    pair = {3'd0, 3'd1};
        3'd1:    pair = {3'd3, 3'd4};
        3'd2:    pair = {3'd0, 3'd3};
        3'd3:    pair = {3'd1, 3'd4};
        default: pair = {3'd0, 3'd0};
      endcase
    end
    return pair;
  endfunction

endpackage

// File: rtl/move_eval_if.sv
// Request/result bundle between tour fetch and the move evaluator.
interface move_eval_if #(
  parameter int COORD_W = 32,
  parameter int DIST_W  = 32
);
  logic                start;
  logic                mode;
  logic [DIST_W+2:0]   thr;
  logic [COORD_W-1:0]  px [6];
  logic [COORD_W-1:0]  py [6];
  logic                busy;
  logic                done;
  logic                res;
  logic [DIST_W+2:0]   gain;

  modport master (output start, mode, thr, px, py, input busy, done, res, gain);
  modport slave  (input start, mode, thr, px, py, output busy, done, res, gain);
endinterface

// File: rtl/move_eval_dist_pipe.sv
// Registered-input Manhattan distance unit with DIST_LAT extra stages;
// a valid bit and an old/new tag travel alongside each result.
module move_eval_dist_pipe #(
  parameter int COORD_W  = 32,
  parameter int DIST_W   = 32,
  parameter int DIST_LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic               i_tag,
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  output logic               o_valid,
  output logic               o_tag,
  output logic [DIST_W-1:0]  o_dist
);
  localparam int SW = (COORD_W + 1 > DIST_W) ? COORD_W + 1 : DIST_W;

  logic               r_valid, r_tag;
  logic [COORD_W-1:0] r_ax, r_ay, r_bx, r_by;
  logic [COORD_W-1:0] w_dx, w_dy;
  logic [SW-1:0]      w_sum;
  logic               w_ovf;
  logic [DIST_W-1:0]  w_dist;

  // Input register stage of the distance unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= 1'b0;
      r_ax    <= {COORD_W{1'b0}};
      r_ay    <= {COORD_W{1'b0}};
      r_bx    <= {COORD_W{1'b0}};
      r_by    <= {COORD_W{1'b0}};
    end else begin
      r_valid <= i_valid;
      r_tag   <= i_tag;
      if (i_valid) begin
        r_ax <= i_ax;
        r_ay <= i_ay;
        r_bx <= i_bx;
        r_by <= i_by;
      end
    end
  end

  assign w_dx   = (r_ax >= r_bx) ? (r_ax - r_bx) : (r_bx - r_ax);
  assign w_dy   = (r_ay >= r_by) ? (r_ay - r_by) : (r_by - r_ay);
  assign w_sum  = SW'(w_dx) + SW'(w_dy);
  // Saturate rather than wrap if the metric outgrows the result width.
  assign w_ovf  = |(w_sum >> DIST_W);
  assign w_dist = w_ovf ? {DIST_W{1'b1}} : w_sum[DIST_W-1:0];

  generate
    if (DIST_LAT == 0) begin : g_nolat
      assign o_valid = r_valid;
      assign o_tag   = r_tag;
      assign o_dist  = w_dist;
    end else begin : g_lat
      logic [DIST_W-1:0] r_dly  [DIST_LAT];
      logic              r_vdly [DIST_LAT];
      logic              r_tdly [DIST_LAT];

      // Extra latency stages; data, valid and tag shift together.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DIST_LAT; i++) begin
            r_dly[i]  <= {DIST_W{1'b0}};
            r_vdly[i] <= 1'b0;
            r_tdly[i] <= 1'b0;
          end
        end else begin
          r_dly[0]  <= w_dist;
          r_vdly[0] <= r_valid;
          r_tdly[0] <= r_tag;
          for (int i = 1; i < DIST_LAT; i++) begin
            r_dly[i]  <= r_dly[i-1];
            r_vdly[i] <= r_vdly[i-1];
            r_tdly[i] <= r_tdly[i-1];
          end
        end
      end

      assign o_valid = r_vdly[DIST_LAT-1];
      assign o_tag   = r_tdly[DIST_LAT-1];
      assign o_dist  = r_dly[DIST_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/move_eval.sv
// TSP move evaluator: feeds removed/added edges through one distance unit,
// then reports gain = sum_old - sum_new and a strict accept against thr.
module move_eval
  import move_eval_pkg::*;
#(
  parameter int COORD_W  = 32,
  parameter int DIST_W   = 32,
  parameter int DIST_LAT = 0
) (
  input logic        clk,
  input logic        rst_n,
  move_eval_if.slave bus
);
  localparam int GW   = DIST_W + 3;
  localparam int SUMW = DIST_W + 2;
  localparam int CW   = (DIST_LAT > 0) ? $clog2(DIST_LAT + 1) : 1;

  state_t             r_state;
  mode_t              r_mode;
  logic [2:0]         r_idx;
  logic [CW-1:0]      r_drain_cnt;
  logic [COORD_W-1:0] r_px [6];
  logic [COORD_W-1:0] r_py [6];
  logic [GW-1:0]      r_thr, r_gain;
  logic [SUMW-1:0]    r_sum_old, r_sum_new;
  logic               r_busy, r_done, r_res;

  logic [5:0]         w_pair;
  logic [2:0]         w_a, w_b, w_last_idx;
  logic               w_is_new, w_accept;
  logic               w_pv, w_ptag;
  logic [DIST_W-1:0]  w_pdist;
  logic [GW-1:0]      w_gain;

  assign w_pair     = edge_pair(r_mode, r_idx);
  assign w_a        = w_pair[5:3];
  assign w_b        = w_pair[2:0];
  assign w_last_idx = (r_mode == MV_SWAP) ? 3'(2 * N_EDGES_SWAP - 1) : 3'(2 * N_EDGES_2OPT - 1);
  assign w_is_new   = (r_mode == MV_SWAP) ? (r_idx >= 3'(N_EDGES_SWAP)) : (r_idx >= 3'(N_EDGES_2OPT));
  // The done cycle is already IDLE, so a start there must be masked explicitly.
  assign w_accept   = (r_state == IDLE) && bus.start && !r_done;
  assign w_gain     = GW'(r_sum_old) - GW'(r_sum_new);

  move_eval_dist_pipe #(
    .COORD_W (COORD_W),
    .DIST_W  (DIST_W),
    .DIST_LAT(DIST_LAT)
  ) u_dist (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(r_state == FEED),
    .i_tag  (w_is_new),
    .i_ax   (r_px[w_a]),
    .i_ay   (r_py[w_a]),
    .i_bx   (r_px[w_b]),
    .i_by   (r_py[w_b]),
    .o_valid(w_pv),
    .o_tag  (w_ptag),
    .o_dist (w_pdist)
  );

  // Control FSM, accumulators and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= MV_SWAP;
      r_idx       <= 3'd0;
      r_drain_cnt <= {CW{1'b0}};
      r_thr       <= {GW{1'b0}};
      r_gain      <= {GW{1'b0}};
      r_sum_old   <= {SUMW{1'b0}};
      r_sum_new   <= {SUMW{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res       <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        r_px[i] <= {COORD_W{1'b0}};
        r_py[i] <= {COORD_W{1'b0}};
      end
    end else begin
      r_done <= 1'b0;
      if (w_pv) begin
        if (w_ptag) r_sum_new <= r_sum_new + SUMW'(w_pdist);
        else        r_sum_old <= r_sum_old + SUMW'(w_pdist);
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode    <= mode_t'(bus.mode);
            r_thr     <= bus.thr;
            r_px      <= bus.px;
            r_py      <= bus.py;
            r_sum_old <= {SUMW{1'b0}};
            r_sum_new <= {SUMW{1'b0}};
            r_idx     <= 3'd0;
            r_busy    <= 1'b1;
            r_state   <= FEED;
          end
        end
        FEED: begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == w_last_idx) begin
            r_drain_cnt <= {CW{1'b0}};
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt + CW'(1);
          if (r_drain_cnt == CW'(DIST_LAT)) r_state <= CMP;
        end
        CMP: begin
          r_gain  <= w_gain;
          r_res   <= ($signed(w_gain) > $signed(r_thr));
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.res  = r_res;
  assign bus.gain = r_gain;

endmodule

// File: tb/tb_move_eval.sv
// Self-checking bench for move_eval: directed table, random moves against a
// distance-rule model, plus start-ignore and mid-run reset sequences.
module tb_move_eval;
  localparam int CW = 32;
  localparam int DW = 32;
  localparam int GW = DW + 3;

  typedef struct packed {
    logic            sel;   // 0: DIST_LAT=0 instance, 1: DIST_LAT=3 instance
    logic            mode;
    logic [5:0][CW-1:0] x;
    logic [GW-1:0]   thr;
    logic [GW-1:0]   g;
    logic            r;
    logic [7:0]      lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic t_start, t_mode, t_sel;
  logic [GW-1:0] t_thr;
  logic [CW-1:0] t_px [6];
  logic [CW-1:0] t_py [6];
  logic o_busy, o_done, o_res;
  logic [GW-1:0] o_gain;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  move_eval_if #(.COORD_W(CW), .DIST_W(DW)) if0 ();
  move_eval_if #(.COORD_W(CW), .DIST_W(DW)) if3 ();

  assign if0.start = t_start & ~t_sel;
  assign if0.mode  = t_mode;
  assign if0.thr   = t_thr;
  assign if0.px    = t_px;
  assign if0.py    = t_py;
  assign if3.start = t_start & t_sel;
  assign if3.mode  = t_mode;
  assign if3.thr   = t_thr;
  assign if3.px    = t_px;
  assign if3.py    = t_py;

  move_eval #(.COORD_W(CW), .DIST_W(DW), .DIST_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  move_eval #(.COORD_W(CW), .DIST_W(DW), .DIST_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  assign o_busy = t_sel ? if3.busy : if0.busy;
  assign o_done = t_sel ? if3.done : if0.done;
  assign o_res  = t_sel ? if3.res  : if0.res;
  assign o_gain = t_sel ? if3.gain : if0.gain;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint dist1(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? longint'(a - b) : longint'(b - a);
  endfunction

  // Gain from the move definitions with collinear points (distance = |dx|).
  function automatic longint model_gain(input logic mode, input logic [5:0][CW-1:0] x);
    longint s_old, s_new;
    if (!mode) begin
      s_old = dist1(x[0], x[1]) + dist1(x[1], x[2]) + dist1(x[3], x[4]) + dist1(x[4], x[5]);
      s_new = dist1(x[0], x[4]) + dist1(x[4], x[2]) + dist1(x[3], x[1]) + dist1(x[1], x[5]);
    end else begin
      s_old = dist1(x[0], x[1]) + dist1(x[3], x[4]);
      s_new = dist1(x[0], x[3]) + dist1(x[1], x[4]);
    end
    return s_old - s_new;
  endfunction

  function automatic vec_t mk(input logic sel, input logic mode, input int x0, input int x1,
                              input int x2, input int x3, input int x4, input int x5,
                              input longint thr, input longint g, input logic r, input int lat);
    vec_t v;
    v.sel  = sel;
    v.mode = mode;
    v.x[0] = CW'(x0); v.x[1] = CW'(x1); v.x[2] = CW'(x2);
    v.x[3] = CW'(x3); v.x[4] = CW'(x4); v.x[5] = CW'(x5);
    v.thr  = GW'(thr);
    v.g    = GW'(g);
    v.r    = r;
    v.lat  = 8'(lat);
    return v;
  endfunction

  task automatic drive(input logic mode, input logic [5:0][CW-1:0] x, input logic [GW-1:0] thr);
    t_mode = mode;
    t_thr  = thr;
    for (int i = 0; i < 6; i++) begin
      t_px[i] = x[i];
      t_py[i] = '0;
    end
  endtask

  task automatic scramble();
    t_mode = ~t_mode;
    t_thr  = GW'($urandom);
    for (int i = 0; i < 6; i++) t_px[i] = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (o_done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    t_sel = v.sel;
    drive(v.mode, v.x, v.thr);
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    check({tag, " busy"}, 64'(o_busy), 64'd1);
    scramble();
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " gain"}, 64'(o_gain), 64'(v.g));
    check({tag, " res"}, 64'(o_res), 64'(v.r));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(o_done), 64'd0);
  endtask

  vec_t vecs [12];
  vec_t rv;
  vec_t c1, c2;

  initial begin
    int lat, seen;
    longint thr_l;
    rst_n = 1'b0; t_start = 1'b0; t_sel = 1'b0; t_mode = 1'b0; t_thr = '0;
    for (int i = 0; i < 6; i++) begin t_px[i] = '0; t_py[i] = '0; end

    vecs[0]  = mk(1'b0, 1'b0, 0, 10, 2, 9, 1, 11, 0, 32, 1'b1, 10);
    vecs[1]  = mk(1'b0, 1'b0, 0, 1, 2, 9, 10, 11, 0, -32, 1'b0, 10);
    vecs[2]  = mk(1'b0, 1'b1, 0, 10, 7, 1, 11, 3, 0, 18, 1'b1, 6);
    vecs[3]  = mk(1'b1, 1'b1, 0, 10, 7, 1, 11, 3, 0, 18, 1'b1, 9);
    vecs[4]  = mk(1'b0, 1'b0, 0, 10, 2, 9, 1, 11, 32, 32, 1'b0, 10);
    vecs[5]  = mk(1'b0, 1'b0, 0, 10, 2, 9, 1, 11, 31, 32, 1'b1, 10);
    vecs[6]  = mk(1'b0, 1'b0, 5, 5, 5, 5, 5, 5, 0, 0, 1'b0, 10);
    vecs[7]  = mk(1'b1, 1'b0, 0, 10, 2, 9, 1, 11, 0, 32, 1'b1, 13);
    vecs[8]  = mk(1'b0, 1'b0, 0, 1, 2, 9, 10, 11, -33, -32, 1'b1, 10);
    vecs[9]  = mk(1'b1, 1'b0, 0, 1, 2, 9, 10, 11, -32, -32, 1'b0, 13);
    vecs[10] = mk(1'b0, 1'b1, 0, -1, 0, 0, -1, 0, 0, 64'sd8589934590, 1'b1, 6);
    vecs[11] = mk(1'b0, 1'b1, 0, 0, 0, -1, -1, 0, -64'sd8589934590, -64'sd8589934590, 1'b0, 6);
    c1 = vecs[0];
    c2 = vecs[1];

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      t_sel = s[0];
      #1;
      check($sformatf("reset busy%0d", s), 64'(o_busy), 64'd0);
      check($sformatf("reset done%0d", s), 64'(o_done), 64'd0);
      check($sformatf("reset res%0d", s), 64'(o_res), 64'd0);
      check($sformatf("reset gain%0d", s), 64'(o_gain), 64'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      rv.sel  = 1'($urandom_range(0, 1));
      rv.mode = 1'($urandom_range(0, 1));
      for (int k = 0; k < 6; k++) rv.x[k] = (i % 2 == 0) ? CW'($urandom_range(0, 50)) : CW'($urandom);
      thr_l = model_gain(rv.mode, rv.x);
      rv.g  = GW'(thr_l);
      case ($urandom_range(0, 2))
        0:       thr_l = thr_l;
        1:       thr_l = thr_l - 1;
        default: thr_l = longint'($urandom) - longint'($urandom);
      endcase
      rv.thr = GW'(thr_l);
      rv.r   = (model_gain(rv.mode, rv.x) > thr_l);
      rv.lat = 8'((rv.mode ? 6 : 10) + (rv.sel ? 3 : 0));
      run_vec(rv, $sformatf("rand%0d", i));
    end

    // Start while busy (different points) must not disturb the running move.
    @(negedge clk);
    t_sel = 1'b0;
    drive(c1.mode, c1.x, c1.thr);
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        drive(c2.mode, c2.x, c2.thr);
        t_start = 1'b1;
      end
      if (n == 4) t_start = 1'b0;
      if (o_done) begin
        lat = n;
        break;
      end
    end
    check("busy-start latency", 64'(lat), 64'd10);
    check("busy-start gain", 64'(o_gain), 64'(c1.g));
    check("busy-start res", 64'(o_res), 64'd1);
    // Start raised in the done cycle is ignored; held one more cycle it is accepted.
    drive(c2.mode, c2.x, c2.thr);
    t_start = 1'b1;
    @(posedge clk); #1;
    check("done-cycle start ignored", 64'(o_busy), 64'd0);
    check("held gain", 64'(o_gain), 64'(c1.g));
    @(posedge clk); #1;
    t_start = 1'b0;
    check("next-cycle start accepted", 64'(o_busy), 64'd1);
    wait_done(lat);
    check("b2b latency", 64'(lat), 64'd10);
    check("b2b gain", 64'(o_gain), 64'(c2.g));
    check("b2b res", 64'(o_res), 64'd0);

    // Reset in the middle of an evaluation aborts it without a done pulse.
    @(negedge clk);
    drive(c1.mode, c1.x, c1.thr);
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(o_busy), 64'd0);
    check("abort done", 64'(o_done), 64'd0);
    check("abort res", 64'(o_res), 64'd0);
    check("abort gain", 64'(o_gain), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (o_done) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);
    run_vec(c2, "after-abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
